// File: rtl/noc_out_arb_if.sv
// Link-side bundle of the output arbiter: requester flits in, registered link flit out,
// credit return and status.
interface noc_out_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         dout;
  logic                          dout_valid;
  logic                          yummy_in;
  logic [GW-1:0]                 grant_id;
  logic                          busy;
  logic [3:0]                    credit_cnt;
  logic                          credit_err;

  modport slave (
    input  req_data, req_valid, yummy_in,
    output req_ready, dout, dout_valid, grant_id, busy, credit_cnt, credit_err
  );

  modport master (
    output req_data, req_valid, yummy_in,
    input  req_ready, dout, dout_valid, grant_id, busy, credit_cnt, credit_err
  );
endinterface

// File: rtl/noc_out_arb.sv
// Credit-based wormhole arbiter: round-robin packet grants onto one outgoing link,
// grant held header..tail, flits registered onto the link while credits last.
module noc_out_arb_lane #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_LSB    = 22,
  parameter int LEN_WIDTH  = 8
)(
  input  logic [DATA_WIDTH-1:0] flit,
  input  logic                  sel,
  input  logic                  accept,
  output logic                  ready,
  output logic [LEN_WIDTH-1:0]  len
);
  assign len   = flit[LEN_LSB +: LEN_WIDTH];
  assign ready = accept & sel;
endmodule

module noc_out_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CREDITS    = 4,
  parameter int LEN_LSB    = 22,
  parameter int LEN_WIDTH  = 8,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
  input  logic clk,
  input  logic rst_n,
  noc_out_arb_if.slave link
);
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, nextState;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] reqFlit;
  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  laneLen;
  logic [DATA_WIDTH-1:0]              selFlit, doutQ;
  logic [LEN_WIDTH-1:0]               hdrLen, remaining;
  logic [GW-1:0]                      owner, rrPtr, winner, selIdx;
  logic [3:0]                         creditCnt;
  logic                               found, canSend, accept, dValid, creditErr;

  assign reqFlit = link.req_data;
  assign canSend = (creditCnt != 4'd0);

  function automatic logic [GW-1:0] wrapInc(input logic [GW-1:0] idx);
    return (int'(idx) == NUM_REQ-1) ? '0 : idx + 1'b1;
  endfunction

  // First valid requester at or after rrPtr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && link.req_valid[(int'(rrPtr) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = GW'((int'(rrPtr) + k) % NUM_REQ);
      end
    end
  end

  // Reset gates accept so no ready escapes while rst_n is low.
  always_comb begin
    nextState = state;
    selIdx    = (state == LOCK) ? owner : winner;
    selFlit   = reqFlit[selIdx];
    hdrLen    = laneLen[selIdx];
    accept    = rst_n & canSend & ((state == LOCK) ? link.req_valid[owner] : found);
    case (state)
      IDLE: if (accept && hdrLen != '0) nextState = LOCK;
      LOCK: if (accept && remaining == LEN_WIDTH'(1)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    noc_out_arb_lane #(
      .DATA_WIDTH(DATA_WIDTH), .LEN_LSB(LEN_LSB), .LEN_WIDTH(LEN_WIDTH)
    ) u_lane (
      .flit   (reqFlit[i]),
      .sel    (selIdx == GW'(i)),
      .accept (accept),
      .ready  (link.req_ready[i]),
      .len    (laneLen[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doutQ     <= '0;
      dValid    <= 1'b0;
      owner     <= '0;
      rrPtr     <= '0;
      remaining <= '0;
      creditCnt <= CRED_MAX;
      creditErr <= 1'b0;
    end else begin
      dValid <= accept;
      if (accept) doutQ <= selFlit;
      if (accept) begin
        if (state == IDLE) begin
          if (hdrLen == '0) rrPtr <= wrapInc(winner);
          else begin
            owner     <= winner;
            remaining <= hdrLen;
          end
        end else begin
          remaining <= remaining - 1'b1;
          if (remaining == LEN_WIDTH'(1)) rrPtr <= wrapInc(owner);
        end
      end
      // Accept plus yummy in the same cycle nets to no change.
      if (accept && !link.yummy_in) creditCnt <= creditCnt - 1'b1;
      else if (!accept && link.yummy_in) begin
        if (creditCnt == CRED_MAX) creditErr <= 1'b1;
        else                       creditCnt <= creditCnt + 1'b1;
      end
    end
  end

  assign link.dout       = doutQ;
  assign link.dout_valid = dValid;
  assign link.grant_id   = owner;
  assign link.busy       = (state == LOCK);
  assign link.credit_cnt = creditCnt;
  assign link.credit_err = creditErr;
endmodule

// File: tb/tb_noc_out_arb.sv
// Directed bench for noc_out_arb: inputs driven at negedge, outputs sampled at negedge
// (registered) or 1ns after driving (combinational req_ready).
module tb_noc_out_arb;
  localparam int NR = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  noc_out_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GW(2)) link();
  noc_out_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CREDITS(4), .LEN_LSB(22), .LEN_WIDTH(8))
    dut (.clk(clk), .rst_n(rst_n), .link(link));

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] hdr(input logic [7:0] len, input logic [15:0] tag);
    logic [63:0] f;
    f = '0;
    f[63:48] = 16'hC0DE;
    f[29:22] = len;
    f[15:0]  = tag;
    return f;
  endfunction

  function automatic logic [63:0] pay(input logic [15:0] tag);
    return {16'hDA7A, 32'h1234_5678, tag};
  endfunction

  task automatic setReq(input int i, input logic [63:0] f, input logic v);
    link.req_data[i*DW +: DW] = f;
    link.req_valid[i] = v;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    link.req_valid = '0;
    link.req_data = '0;
    link.yummy_in = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic restoreCredits();
    link.req_valid = '0;
    for (int i = 0; i < 20 && link.credit_cnt != 4'd4; i++) begin
      link.yummy_in = 1'b1;
      @(negedge clk);
    end
    link.yummy_in = 1'b0;
  endtask

  task automatic test_reset();
    link.req_data = '0;
    link.yummy_in = 1'b0;
    #1 rst_n = 1'b0;
    link.req_valid = 4'hF;
    @(negedge clk); @(negedge clk);
    checks++; if (link.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", link.req_ready); end
    checks++; if (link.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got %b exp 0", link.dout_valid); end
    checks++; if (link.dout !== 64'h0) begin errors++; $display("FAIL rst_dout got %h exp 0", link.dout); end
    checks++; if (link.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", link.busy); end
    checks++; if (link.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d exp 0", link.grant_id); end
    checks++; if (link.credit_cnt !== 4'd4) begin errors++; $display("FAIL rst_credit got %0d exp 4", link.credit_cnt); end
    checks++; if (link.credit_err !== 1'b0) begin errors++; $display("FAIL rst_cerr got %b exp 0", link.credit_err); end
    link.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_credit_exhaustion();
    logic [63:0] f [6];
    logic got;
    doReset();
    f[0] = hdr(8'd5, 16'h100);
    for (int k = 1; k < 6; k++) f[k] = pay(16'(16'h100 + k));
    for (int k = 0; k < 4; k++) begin
      setReq(0, f[k], 1'b1);
      #1;
      checks++; if (link.req_ready !== 4'b0001) begin errors++; $display("FAIL ce_ready%0d got %b exp 0001", k, link.req_ready); end
      @(negedge clk);
      checks++; if ({link.dout_valid, link.dout} !== {1'b1, f[k]}) begin errors++; $display("FAIL ce_dout%0d got %b/%h exp 1/%h", k, link.dout_valid, link.dout, f[k]); end
    end
    checks++; if (link.credit_cnt !== 4'd0) begin errors++; $display("FAIL ce_credit0 got %0d exp 0", link.credit_cnt); end
    setReq(0, f[4], 1'b1);
    #1;
    checks++; if (link.req_ready !== 4'b0000) begin errors++; $display("FAIL ce_stall_ready got %b exp 0000", link.req_ready); end
    @(negedge clk);
    checks++; if (link.dout_valid !== 1'b0) begin errors++; $display("FAIL ce_stall_valid got %b exp 0", link.dout_valid); end
    link.yummy_in = 1'b1;
    @(negedge clk);
    link.yummy_in = 1'b0;
    checks++; if (link.credit_cnt !== 4'd1) begin errors++; $display("FAIL ce_credit1 got %0d exp 1", link.credit_cnt); end
    #1;
    checks++; if (link.req_ready !== 4'b0001) begin errors++; $display("FAIL ce_resume_ready got %b exp 0001", link.req_ready); end
    @(negedge clk);
    checks++; if ({link.dout_valid, link.dout} !== {1'b1, f[4]}) begin errors++; $display("FAIL ce_resume_dout got %b/%h exp 1/%h", link.dout_valid, link.dout, f[4]); end
    checks++; if (link.busy !== 1'b1) begin errors++; $display("FAIL ce_busy_hold got %b exp 1", link.busy); end
    setReq(0, f[5], 1'b1);
    link.yummy_in = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      if (link.req_ready[0]) got = 1'b1;
      @(negedge clk);
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ce_tail_timeout got %b exp 1", got); end
    checks++; if ({link.dout_valid, link.dout} !== {1'b1, f[5]}) begin errors++; $display("FAIL ce_tail_dout got %b/%h exp 1/%h", link.dout_valid, link.dout, f[5]); end
    checks++; if (link.busy !== 1'b0) begin errors++; $display("FAIL ce_tail_busy got %b exp 0", link.busy); end
    restoreCredits();
  endtask

  task automatic test_round_robin();
    logic [3:0] expRdy;
    doReset();
    for (int i = 0; i < NR; i++) setReq(i, hdr(8'd0, 16'(16'h200 + i)), 1'b1);
    for (int c = 0; c < 6; c++) begin
      expRdy = 4'b0001 << (c % 4);
      #1;
      checks++; if (link.req_ready !== expRdy) begin errors++; $display("FAIL rr_ready%0d got %b exp %b", c, link.req_ready, expRdy); end
      @(negedge clk);
      checks++; if ({link.dout_valid, link.dout} !== {1'b1, hdr(8'd0, 16'(16'h200 + c % 4))}) begin errors++; $display("FAIL rr_dout%0d got %b/%h exp req%0d", c, link.dout_valid, link.dout, c % 4); end
      link.yummy_in = 1'b1;
    end
    restoreCredits();
  endtask

  task automatic test_wormhole();
    doReset();
    setReq(0, hdr(8'd3, 16'h300), 1'b1);
    setReq(1, hdr(8'd1, 16'h310), 1'b1);
    #1;
    checks++; if (link.req_ready !== 4'b0001) begin errors++; $display("FAIL wh_hdr_ready got %b exp 0001", link.req_ready); end
    @(negedge clk);
    checks++; if (link.grant_id !== 2'd0 || link.busy !== 1'b1) begin errors++; $display("FAIL wh_lock got %0d/%b exp 0/1", link.grant_id, link.busy); end
    link.req_valid[0] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #1;
      checks++; if (link.req_ready !== 4'b0000) begin errors++; $display("FAIL wh_gap_ready%0d got %b exp 0000", j, link.req_ready); end
      @(negedge clk);
      checks++; if (link.dout_valid !== 1'b0 || link.busy !== 1'b1) begin errors++; $display("FAIL wh_gap%0d got %b/%b exp 0/1", j, link.dout_valid, link.busy); end
    end
    link.yummy_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      setReq(0, pay(16'(16'h300 + k)), 1'b1);
      #1;
      checks++; if (link.req_ready !== 4'b0001) begin errors++; $display("FAIL wh_pay_ready%0d got %b exp 0001", k, link.req_ready); end
      @(negedge clk);
      checks++; if (link.dout !== pay(16'(16'h300 + k))) begin errors++; $display("FAIL wh_pay_dout%0d got %h exp %h", k, link.dout, pay(16'(16'h300 + k))); end
    end
    checks++; if (link.busy !== 1'b0) begin errors++; $display("FAIL wh_tail_busy got %b exp 0", link.busy); end
    link.req_valid[0] = 1'b0;
    link.yummy_in = 1'b0;
    #1;
    checks++; if (link.req_ready !== 4'b0010) begin errors++; $display("FAIL wh_next_ready got %b exp 0010", link.req_ready); end
    @(negedge clk);
    checks++; if (link.grant_id !== 2'd1 || link.busy !== 1'b1) begin errors++; $display("FAIL wh_next_grant got %0d/%b exp 1/1", link.grant_id, link.busy); end
    checks++; if (link.dout !== hdr(8'd1, 16'h310)) begin errors++; $display("FAIL wh_next_dout got %h exp %h", link.dout, hdr(8'd1, 16'h310)); end
  endtask

  task automatic test_credit_edges();
    doReset();
    for (int k = 0; k < 3; k++) begin
      setReq(0, hdr(8'd0, 16'(16'h400 + k)), 1'b1);
      @(negedge clk);
    end
    checks++; if (link.credit_cnt !== 4'd1) begin errors++; $display("FAIL edge_cnt1 got %0d exp 1", link.credit_cnt); end
    setReq(0, hdr(8'd0, 16'h403), 1'b1);
    link.yummy_in = 1'b1;
    #1;
    checks++; if (link.req_ready !== 4'b0001) begin errors++; $display("FAIL edge_both_ready got %b exp 0001", link.req_ready); end
    @(negedge clk);
    checks++; if (link.credit_cnt !== 4'd1) begin errors++; $display("FAIL edge_both_cnt got %0d exp 1", link.credit_cnt); end
    link.req_valid = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (link.credit_cnt !== 4'd4 || link.credit_err !== 1'b0) begin errors++; $display("FAIL edge_full got %0d/%b exp 4/0", link.credit_cnt, link.credit_err); end
    @(negedge clk);
    link.yummy_in = 1'b0;
    checks++; if (link.credit_cnt !== 4'd4 || link.credit_err !== 1'b1) begin errors++; $display("FAIL edge_overflow got %0d/%b exp 4/1", link.credit_cnt, link.credit_err); end
    @(negedge clk); @(negedge clk);
    checks++; if (link.credit_err !== 1'b1) begin errors++; $display("FAIL edge_sticky got %b exp 1", link.credit_err); end
  endtask

  task automatic test_reset_mid();
    doReset();
    checks++; if (link.credit_err !== 1'b0) begin errors++; $display("FAIL rm_cerr_clear got %b exp 0", link.credit_err); end
    setReq(2, hdr(8'd4, 16'h500), 1'b1);
    @(negedge clk);
    setReq(2, pay(16'h501), 1'b1);
    @(negedge clk);
    setReq(2, pay(16'h502), 1'b1);
    checks++; if (link.grant_id !== 2'd2 || link.busy !== 1'b1) begin errors++; $display("FAIL rm_pre got %0d/%b exp 2/1", link.grant_id, link.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (link.busy !== 1'b0 || link.grant_id !== 2'd0) begin errors++; $display("FAIL rm_state got %b/%0d exp 0/0", link.busy, link.grant_id); end
    checks++; if (link.credit_cnt !== 4'd4) begin errors++; $display("FAIL rm_credit got %0d exp 4", link.credit_cnt); end
    checks++; if ({link.dout_valid, link.dout} !== 65'h0) begin errors++; $display("FAIL rm_dout got %b/%h exp 0/0", link.dout_valid, link.dout); end
    checks++; if (link.req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready got %b exp 0000", link.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    setReq(1, hdr(8'd0, 16'h510), 1'b1);
    setReq(2, hdr(8'd0, 16'h520), 1'b1);
    #1;
    checks++; if (link.req_ready !== 4'b0010) begin errors++; $display("FAIL rm_first_ready got %b exp 0010", link.req_ready); end
    @(negedge clk);
    checks++; if (link.dout !== hdr(8'd0, 16'h510)) begin errors++; $display("FAIL rm_first_dout got %h exp %h", link.dout, hdr(8'd0, 16'h510)); end
  endtask

  task automatic test_max_len();
    logic [63:0] f;
    int badReady, badDout, badBusy;
    badReady = 0; badDout = 0; badBusy = 0;
    doReset();
    for (int k = 0; k < 256; k++) begin
      f = (k == 0) ? hdr(8'd255, 16'h600) : pay(16'(16'h600 + k));
      setReq(3, f, 1'b1);
      #1;
      if (link.req_ready !== 4'b1000) badReady++;
      @(negedge clk);
      if ({link.dout_valid, link.dout} !== {1'b1, f}) badDout++;
      if (k < 255 && link.busy !== 1'b1) badBusy++;
      link.yummy_in = 1'b1;
    end
    checks++; if (badReady != 0) begin errors++; $display("FAIL ml_ready bad cycles %0d exp 0", badReady); end
    checks++; if (badDout != 0) begin errors++; $display("FAIL ml_dout bad flits %0d exp 0", badDout); end
    checks++; if (badBusy != 0) begin errors++; $display("FAIL ml_busy bad cycles %0d exp 0", badBusy); end
    checks++; if (link.busy !== 1'b0) begin errors++; $display("FAIL ml_busy_drop got %b exp 0", link.busy); end
    for (int i = 0; i < NR; i++) setReq(i, hdr(8'd0, 16'(16'h6F0 + i)), 1'b1);
    #1;
    checks++; if (link.req_ready !== 4'b0001) begin errors++; $display("FAIL ml_wrap_ready got %b exp 0001", link.req_ready); end
    @(negedge clk);
    link.req_valid = '0;
    link.yummy_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    link.req_valid = '0;
    link.req_data = '0;
    link.yummy_in = 1'b0;
    test_reset();
    test_credit_exhaustion();
    test_round_robin();
    test_wormhole();
    test_credit_edges();
    test_reset_mid();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
